// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core widths, constants and types
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_2r1w_if.sv
// rtl/regfile_2r1w_if.sv - decode/writeback port bundle for the register file
interface regfile_2r1w_if;
  import riscv_pkg::*;

  logic      we;
  logic      enable;
  reg_addr_t waddr;
  xlen_t     wdata;
  reg_addr_t raddr1;
  reg_addr_t raddr2;
  xlen_t     rdata1;
  xlen_t     rdata2;

  modport master (
    output we, enable, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, enable, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile_cell.sv
// rtl/regfile_cell.sv - one XLEN-wide register entry with sync reset and load
module regfile_cell
  import riscv_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  xlen_t d,
  output xlen_t q
);

  // Reset wins over a coincident load so a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - integer register file, two bypassed reads, one write
module regfile_2r1w
  import riscv_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  regfile_2r1w_if.slave rf
);

  logic  wr_en;
  xlen_t mem [NREG];

  assign wr_en  = rf.we && rf.enable;
  assign mem[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_cell
    logic load;
    assign load = wr_en && (rf.waddr == reg_addr_t'(i));

    regfile_cell u_cell (
      .clk  (Clk),
      .rst  (Reset),
      .load (load),
      .d    (rf.wdata),
      .q    (mem[i])
    );
  end

  // Index 0 is checked before bypass so a discarded write to x0 never leaks out.
  always_comb begin
    rf.rdata1 = '0;
    if (Reset || rf.raddr1 == REG_ZERO) begin
      rf.rdata1 = '0;
    end else if (wr_en && rf.waddr == rf.raddr1) begin
      rf.rdata1 = rf.wdata;
    end else begin
      rf.rdata1 = mem[rf.raddr1];
    end
  end

  always_comb begin
    rf.rdata2 = '0;
    if (Reset || rf.raddr2 == REG_ZERO) begin
      rf.rdata2 = '0;
    end else if (wr_en && rf.waddr == rf.raddr2) begin
      rf.rdata2 = rf.wdata;
    end else begin
      rf.rdata2 = mem[rf.raddr2];
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed vector and model-sweep bench for regfile_2r1w
module tb_regfile_2r1w;

  typedef struct {
    logic        rst;
    logic        we;
    logic        en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NV = 20;

  logic        Clk = 1'b0;
  logic        Reset;
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs [NV];
  logic [31:0] model [32];

  regfile_2r1w_if rf ();

  regfile_2r1w dut (
    .Clk   (Clk),
    .Reset (Reset),
    .rf    (rf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic en,
                       input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    Reset     = rst;
    rf.we     = we;
    rf.enable = en;
    rf.waddr  = waddr;
    rf.wdata  = wdata;
    rf.raddr1 = ra1;
    rf.raddr2 = ra2;
  endtask

  function automatic logic [31:0] model_read(input logic rst, input logic we, input logic en,
                                             input logic [4:0] waddr, input logic [31:0] wdata,
                                             input logic [4:0] ra);
    if (rst || ra == 5'd0) return 32'h0;
    if (we && en && waddr == ra) return wdata;
    return model[ra];
  endfunction

  initial begin
    //            rst   we    en    waddr  wdata          ra1    ra2    e1             e2
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 5'd0,  32'h0,        5'd5,  5'd5,  32'h0,         32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0,         32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,         32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,         32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'd10, 32'h12345678, 5'd10, 5'd31, 32'h12345678,  32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd31, 32'h0000ABCD, 5'd10, 5'd31, 32'h12345678,  32'h0000ABCD};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        5'd10, 5'd31, 32'h12345678,  32'h0000ABCD};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'd7,  32'h11111111, 5'd7,  5'd10, 32'h11111111,  32'h12345678};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222,  32'h22222222};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22222222,  32'h22222222};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 5'd3,  32'hAAAA0000, 5'd3,  5'd0,  32'hAAAA0000,  32'h0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 5'd3,  32'h5555FFFF, 5'd3,  5'd3,  32'hAAAA0000,  32'hAAAA0000};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        5'd3,  5'd7,  32'hAAAA0000,  32'h22222222};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd9,  32'h0,         32'h0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        5'd9,  5'd10, 32'h0,         32'h0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 5'd4,  32'h00000001, 5'd4,  5'd0,  32'h00000001,  32'h0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 5'd4,  32'h00000002, 5'd4,  5'd4,  32'h00000002,  32'h00000002};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        5'd4,  5'd31, 32'h00000002,  32'h0};

    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].en, vecs[i].waddr, vecs[i].wdata,
            vecs[i].ra1, vecs[i].ra2);
      #2;
      check("vec_rdata1", i, rf.rdata1, vecs[i].e1);
      check("vec_rdata2", i, rf.rdata2, vecs[i].e2);
    end

    // Clear storage, then sweep random traffic against the reference model.
    @(negedge Clk);
    drive(1'b1, 1'b0, 1'b1, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int k = 0; k < 32; k++) model[k] = 32'h0;

    for (int i = 0; i < 400; i++) begin
      logic        r, w, e;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      @(negedge Clk);
      r  = ($urandom_range(0, 31) == 0);
      w  = ($urandom_range(0, 3) != 0);
      e  = ($urandom_range(0, 4) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(r, w, e, wa, wd, a1, a2);
      #2;
      check("rand_rdata1", i, rf.rdata1, model_read(r, w, e, wa, wd, a1));
      check("rand_rdata2", i, rf.rdata2, model_read(r, w, e, wa, wd, a2));
      if (r) begin
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
      end else if (w && e && wa != 5'd0) begin
        model[wa] = wd;
      end
    end

    for (int k = 0; k < 32; k++) begin
      @(negedge Clk);
      drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 5'(k), 5'(31 - k));
      #2;
      check("final_rdata1", k, rf.rdata1, (k == 0) ? 32'h0 : model[k]);
      check("final_rdata2", k, rf.rdata2, (k == 31) ? 32'h0 : model[31 - k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
